// File: rtl/l2_sched_pkg.sv
// Shared types and constants for the L2 port scheduler and its prefetch line buffer.
package l2_sched_pkg;

  localparam int LINE_OFFSET_W = 5;

  // OR'd below a line tag to form a line-aligned byte address
  localparam logic [LINE_OFFSET_W-1:0] LINE_OFFSET_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE_D,
    S_SERVE_I,
    S_PREFETCH,
    S_BUF_HIT
  } sched_state_t;

endpackage

// File: rtl/pf_line_buffer.sv
// Single-line prefetch buffer: line data, tag and valid, with a combinational tag-compare hit.
module pf_line_buffer #(
  parameter int TAG_W  = 27,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TAG_W-1:0]  load_tag,
  input  logic [LINE_W-1:0] load_line,
  input  logic              inv,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic              valid,
  output logic [TAG_W-1:0]  tag,
  output logic [LINE_W-1:0] line
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      tag   <= load_tag;
    end else if (inv) begin
      valid <= 1'b0;
    end
  end

  // Data needs no reset: it is only observed while valid is set
  always_ff @(posedge clk) begin
    if (load) line <= load_line;
  end

  assign hit = valid && (tag == lookup_tag);

endmodule

// File: rtl/l2_port_scheduler.sv
// Shares the single L2 port between dcache, icache and a next-line prefetcher.
// Prefetcher and line buffer exist only when L2_PREFETCH_EN is defined; otherwise a d-over-i arbiter.
module l2_port_scheduler
  import l2_sched_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              ab_pmem_read,
  output logic              ab_pmem_write,
  output logic [ADDR_W-1:0] ab_pmem_address,
  output logic [LINE_W-1:0] ab_pmem_wdata,
  input  logic [LINE_W-1:0] ab_pmem_rdata,
  input  logic              ab_pmem_resp
);

  localparam int TAG_W = ADDR_W - LINE_OFFSET_W;

  sched_state_t     state;
  logic [TAG_W-1:0] i_tag;
  logic [TAG_W-1:0] d_tag;
  logic             unused_ok;

  assign i_tag     = i_pmem_address[ADDR_W-1:LINE_OFFSET_W];
  assign d_tag     = d_pmem_address[ADDR_W-1:LINE_OFFSET_W];
  assign unused_ok = ^{i_pmem_address[LINE_OFFSET_W-1:0], d_pmem_address[LINE_OFFSET_W-1:0]};

`ifdef L2_PREFETCH_EN
  logic              pf_pending;
  logic [TAG_W-1:0]  pf_tag;
  logic [TAG_W-1:0]  pf_next_tag;
  logic              buf_hit;
  logic              buf_valid;
  logic [TAG_W-1:0]  buf_tag;
  logic [LINE_W-1:0] buf_line;
  logic              buf_load;
  logic              wr_coh;

  // Tag increment wraps, so the line after the top of memory is line 0
  assign pf_next_tag = i_tag + TAG_W'(1);
  assign buf_load    = (state == S_PREFETCH) && ab_pmem_resp;
  // A dcache writeback to the buffered line makes the copy stale
  assign wr_coh      = (state == S_SERVE_D) && ab_pmem_resp && d_pmem_write &&
                       buf_valid && (d_tag == buf_tag);

  pf_line_buffer #(
    .TAG_W (TAG_W),
    .LINE_W(LINE_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_tag  (pf_tag),
    .load_line (ab_pmem_rdata),
    .inv       (wr_coh),
    .lookup_tag(i_tag),
    .hit       (buf_hit),
    .valid     (buf_valid),
    .tag       (buf_tag),
    .line      (buf_line)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
`ifdef L2_PREFETCH_EN
      pf_pending <= 1'b0;
      pf_tag     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (d_pmem_read || d_pmem_write) state <= S_SERVE_D;
`ifdef L2_PREFETCH_EN
          else if (i_pmem_read && buf_hit) state <= S_BUF_HIT;
`endif
          else if (i_pmem_read) state <= S_SERVE_I;
`ifdef L2_PREFETCH_EN
          else if (pf_pending) state <= S_PREFETCH;
`endif
        end
        S_SERVE_D: begin
          if (ab_pmem_resp) begin
            state <= S_IDLE;
`ifdef L2_PREFETCH_EN
            if (wr_coh && (d_tag == pf_tag)) pf_pending <= 1'b0;
`endif
          end
        end
        S_SERVE_I: begin
          if (ab_pmem_resp) begin
            state <= S_IDLE;
`ifdef L2_PREFETCH_EN
            // Skip the prefetch when the next line is already buffered
            if (!(buf_valid && (pf_next_tag == buf_tag))) begin
              pf_pending <= 1'b1;
              pf_tag     <= pf_next_tag;
            end
`endif
          end
        end
`ifdef L2_PREFETCH_EN
        S_PREFETCH: begin
          if (ab_pmem_resp) begin
            state      <= S_IDLE;
            pf_pending <= 1'b0;
          end
        end
        S_BUF_HIT: state <= S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Port routing decodes from state alone; the L2 response passes straight through to the grantee
  always_comb begin
    ab_pmem_read    = 1'b0;
    ab_pmem_write   = 1'b0;
    ab_pmem_address = '0;
    ab_pmem_wdata   = '0;
    i_pmem_rdata    = '0;
    i_pmem_resp     = 1'b0;
    d_pmem_rdata    = '0;
    d_pmem_resp     = 1'b0;
    case (state)
      S_SERVE_D: begin
        ab_pmem_read    = d_pmem_read;
        ab_pmem_write   = d_pmem_write;
        ab_pmem_address = {d_tag, LINE_OFFSET_ZERO};
        ab_pmem_wdata   = d_pmem_wdata;
        d_pmem_rdata    = ab_pmem_rdata;
        d_pmem_resp     = ab_pmem_resp;
      end
      S_SERVE_I: begin
        ab_pmem_read    = 1'b1;
        ab_pmem_address = {i_tag, LINE_OFFSET_ZERO};
        i_pmem_rdata    = ab_pmem_rdata;
        i_pmem_resp     = ab_pmem_resp;
      end
`ifdef L2_PREFETCH_EN
      S_PREFETCH: begin
        ab_pmem_read    = 1'b1;
        ab_pmem_address = {pf_tag, LINE_OFFSET_ZERO};
      end
      S_BUF_HIT: begin
        i_pmem_rdata = buf_line;
        i_pmem_resp  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l2_port_scheduler.sv
// Bench for l2_port_scheduler: vector table for arbitration plus hand sequences for prefetch,
// coherence and reset; prefetch expectations switch on L2_PREFETCH_EN.
module tb_l2_port_scheduler;

  localparam int AW  = 32;
  localparam int LW  = 256;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_pmem_read = 1'b0;
  logic [AW-1:0] i_pmem_address = '0;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read = 1'b0;
  logic          d_pmem_write = 1'b0;
  logic [AW-1:0] d_pmem_address = '0;
  logic [LW-1:0] d_pmem_wdata = '0;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          ab_pmem_read;
  logic          ab_pmem_write;
  logic [AW-1:0] ab_pmem_address;
  logic [LW-1:0] ab_pmem_wdata;
  logic [LW-1:0] ab_pmem_rdata = '0;
  logic          ab_pmem_resp = 1'b0;

  l2_port_scheduler #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .ab_pmem_read(ab_pmem_read), .ab_pmem_write(ab_pmem_write),
    .ab_pmem_address(ab_pmem_address), .ab_pmem_wdata(ab_pmem_wdata),
    .ab_pmem_rdata(ab_pmem_rdata), .ab_pmem_resp(ab_pmem_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic chk_data; logic [LW-1:0] data; } sb_t;
  typedef struct { logic [AW-1:0] addr; logic wr; } l2_t;
  typedef struct {
    logic i_rd; logic [AW-1:0] i_a;
    logic d_rd; logic d_wr; logic [AW-1:0] d_a;
    logic [AW-1:0] exp_addr; logic exp_wr; int exp_first; int exp_nresp;
  } vec_t;

  logic [LW-1:0] exp_i[$];
  sb_t           exp_d[$];
  int            resp_order[$];
  l2_t           l2_log[$];
  vec_t          vt[6];
  int            l2_cnt = 0;
  int            lat_i, lat_d, lat;
  bit            found;

  function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a & ~32'h1F;
  endfunction

  function automatic int n_reads(input logic [AW-1:0] a);
    int n = 0;
    foreach (l2_log[j]) if (!l2_log[j].wr && l2_log[j].addr == a) n++;
    return n;
  endfunction

  function automatic logic [AW-1:0] log_addr(input int k);
    return (k < l2_log.size()) ? l2_log[k].addr : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [7:0] outs_vec();
    return {ab_pmem_read, ab_pmem_write, i_pmem_resp, d_pmem_resp,
            |ab_pmem_address, |ab_pmem_wdata, |i_pmem_rdata, |d_pmem_rdata};
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // L2 model: completes any held request after LAT cycles; read data is a function of the address
  always begin
    @(posedge clk); #1;
    if (rst) begin
      ab_pmem_resp = 1'b0; ab_pmem_rdata = '0; l2_cnt = 0;
    end else if (ab_pmem_resp) begin
      ab_pmem_resp = 1'b0; ab_pmem_rdata = '0;
    end else if (ab_pmem_read || ab_pmem_write) begin
      l2_cnt++;
      if (l2_cnt == LAT) begin
        l2_cnt = 0;
        ab_pmem_resp  = 1'b1;
        ab_pmem_rdata = ab_pmem_write ? '0 : pat(ab_pmem_address);
        l2_log.push_back('{ab_pmem_address, ab_pmem_write});
      end
    end else begin
      l2_cnt = 0;
    end
  end

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (i_pmem_resp) begin
        chk("resp_exclusive", d_pmem_resp, 1'b0);
        chk("i_resp_expected", exp_i.size() > 0, 1'b1);
        if (exp_i.size() > 0) chk("i_rdata", i_pmem_rdata, exp_i.pop_front());
        resp_order.push_back(1);
      end else if (i_pmem_rdata != '0) begin
        chk("i_rdata_idle", i_pmem_rdata, '0);
      end
      if (d_pmem_resp) begin
        chk("d_resp_expected", exp_d.size() > 0, 1'b1);
        if (exp_d.size() > 0) begin
          sb_t e;
          e = exp_d.pop_front();
          if (e.chk_data) chk("d_rdata", d_pmem_rdata, e.data);
        end
        resp_order.push_back(0);
      end else if (d_pmem_rdata != '0) begin
        chk("d_rdata_idle", d_pmem_rdata, '0);
      end
    end
  end

  task automatic i_access(input logic [AW-1:0] a, output int l);
    int t0, k;
    exp_i.push_back(pat(align(a)));
    i_pmem_address = a; i_pmem_read = 1'b1; t0 = cyc; k = 0;
    do begin @(negedge clk); k++; end while (!i_pmem_resp && k < 200);
    chk("i_timeout", i_pmem_resp, 1'b1);
    l = cyc - t0;
    @(posedge clk); #1;
    i_pmem_read = 1'b0;
  endtask

  task automatic d_access(input logic [AW-1:0] a, input logic wr, output int l);
    int t0, k;
    exp_d.push_back('{!wr, pat(align(a))});
    d_pmem_address = a; d_pmem_wdata = ~pat(a);
    d_pmem_read = !wr; d_pmem_write = wr; t0 = cyc; k = 0;
    do begin @(negedge clk); k++; end while (!d_pmem_resp && k < 200);
    chk("d_timeout", d_pmem_resp, 1'b1);
    l = cyc - t0;
    @(posedge clk); #1;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
  endtask

  task automatic wait_quiet();
    int q = 0, k = 0;
    while (q < 3 && k < 500) begin
      @(posedge clk); #1; k++;
      if (ab_pmem_read || ab_pmem_write) q = 0; else q++;
    end
    chk("quiet_timeout", q >= 3, 1'b1);
  endtask

  initial begin
    //           i_rd i_a            d_rd d_wr d_a            exp_addr       wr  first n
    vt[0] = '{1'b0, 32'h0,          1'b1, 1'b0, 32'h8000,     32'h8000,     1'b0, 0, 1};
    vt[1] = '{1'b0, 32'h0,          1'b0, 1'b1, 32'h4047,     32'h4040,     1'b1, 0, 1};
    vt[2] = '{1'b1, 32'h3000,       1'b0, 1'b0, 32'h0,        32'h3000,     1'b0, 1, 1};
    vt[3] = '{1'b1, 32'h1000,       1'b1, 1'b0, 32'h8000,     32'h8000,     1'b0, 0, 2};
    vt[4] = '{1'b1, 32'h2004,       1'b0, 1'b1, 32'h901F,     32'h9000,     1'b1, 0, 2};
    vt[5] = '{1'b1, 32'h5013,       1'b0, 1'b0, 32'h0,        32'h5000,     1'b0, 1, 1};

    // Reset: outputs stay 0 even with a request present, and in the first IDLE cycle
    d_pmem_write = 1'b1; d_pmem_address = 32'h6000;
    repeat (3) @(posedge clk);
    #2 chk("rst_outs", outs_vec(), 8'h0);
    d_pmem_write = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #2 chk("first_idle_outs", outs_vec(), 8'h0);

    // Arbitration vectors
    for (int v = 0; v < 6; v++) begin
      wait_quiet();
      resp_order.delete();
      fork
        if (vt[v].i_rd) i_access(vt[v].i_a, lat_i);
        if (vt[v].d_rd || vt[v].d_wr) d_access(vt[v].d_a, vt[v].d_wr, lat_d);
        begin
          @(posedge clk); #2;
          chk("vec_addr", ab_pmem_address, vt[v].exp_addr);
          chk("vec_rd", ab_pmem_read, !vt[v].exp_wr);
          chk("vec_wr", ab_pmem_write, vt[v].exp_wr);
          if (vt[v].exp_wr) chk("vec_wdata", ab_pmem_wdata, ~pat(vt[v].d_a));
        end
      join
      chk("vec_nresp", resp_order.size(), vt[v].exp_nresp);
      if (resp_order.size() > 0) chk("vec_first", resp_order[0], vt[v].exp_first);
    end

    // Sequential miss then next-line access
    wait_quiet(); l2_log.delete();
    i_access(32'h1000, lat);
    chk("b_miss_lat", lat, LAT);
    wait_quiet();
`ifdef L2_PREFETCH_EN
    chk("b_pf_count", l2_log.size(), 2);
    chk("b_pf_addr", log_addr(1), 32'h1020);
    i_access(32'h1020, lat);
    chk("b_hit_lat", lat, 1);
`else
    chk("b_no_pf", l2_log.size(), 1);
    i_access(32'h1020, lat);
    chk("b_miss2_lat", lat, LAT);
`endif
    wait_quiet();
    chk("b_reads_1020", n_reads(32'h1020), 1);

    // Writeback to the buffered line forces the next icache read to L2
    wait_quiet(); l2_log.delete();
    d_access(32'h1020, 1'b1, lat);
    i_access(32'h1020, lat);
    chk("d_coh_lat", lat, LAT);
    wait_quiet();
    chk("d_coh_l2_addr", log_addr(1), 32'h1020);

    // icache read of the line currently being prefetched
    wait_quiet(); l2_log.delete();
    i_access(32'h1000, lat);
`ifdef L2_PREFETCH_EN
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(posedge clk); #2;
      if (ab_pmem_read && ab_pmem_address == 32'h1020) found = 1'b1;
    end
    chk("e_pf_seen", found, 1'b1);
    i_access(32'h1020, lat);
    chk("e_waited", lat > 1, 1'b1);
`else
    i_access(32'h1020, lat);
    chk("e_miss_lat", lat, LAT);
`endif
    wait_quiet();
    chk("e_one_read", n_reads(32'h1020), 1);

    // Tag increment wraps at the top of memory
    wait_quiet(); l2_log.delete();
    i_access(32'hFFFF_FFE0, lat);
    wait_quiet();
`ifdef L2_PREFETCH_EN
    chk("c_wrap_count", l2_log.size(), 2);
    chk("c_wrap_addr", log_addr(1), 32'h0);
`else
    chk("c_wrap_count", l2_log.size(), 1);
`endif

    // Asynchronous reset in the middle of a dcache writeback
    wait_quiet();
    d_pmem_address = 32'h7000; d_pmem_wdata = pat(32'h7000); d_pmem_write = 1'b1;
    @(posedge clk); #2 chk("f_serve_d_wr", ab_pmem_write, 1'b1);
    @(negedge clk); rst = 1'b1;
    #1 chk("f_rst_async_outs", outs_vec(), 8'h0);
    @(posedge clk); #1;
    chk("f_rst_held_outs", outs_vec(), 8'h0);
    d_pmem_write = 1'b0; rst = 1'b0;
    @(posedge clk); #2 chk("f_idle_outs", outs_vec(), 8'h0);
    i_access(32'h0, lat);
    chk("f_buf_cleared_lat", lat, LAT);
    wait_quiet();
    chk("f_sb_drained", exp_i.size() + exp_d.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
